// File: rtl/multicast_dispatcher_pkg.sv
// Shared state encoding and default widths for the multicast dispatcher and its scan programmer.
package multicast_dispatcher_pkg;

  typedef enum logic [1:0] {
    S_PROG = 2'd0,
    S_RUN  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  localparam int DEF_ADDRESS_WIDTH = 4;
  localparam int DEF_BITWIDTH      = 16;
  localparam int DEF_NUM_UNITS     = 8;

endpackage

// File: rtl/multicast_dispatcher_scan_programmer.sv
// Scan-chain programmer: one-cycle program pulse per accepted cfg tag, done on the NUM_UNITS-th.
// Latency 1 cycle accept->pulse; cfg_ready follows 'active', so no stalls while programming.
module mcast_scan_programmer
  import multicast_dispatcher_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_UNITS     = DEF_NUM_UNITS
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     active,
  input  logic                     restart,
  input  logic                     cfg_valid,
  input  logic [ADDRESS_WIDTH-1:0] cfg_tag,
  output logic                     cfg_ready,
  output logic                     program_o,
  output logic [ADDRESS_WIDTH-1:0] scan_tag,
  output logic                     done
);

  localparam int CNT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_UNITS - 1);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     program_q, program_d;
  logic [ADDRESS_WIDTH-1:0] scan_tag_q, scan_tag_d;
  logic                     accept;

  assign cfg_ready = active;
  assign accept    = active & cfg_valid;
  // A restart in the same cycle as the final tag wins: the chain is not declared programmed.
  assign done      = accept & ~restart & (cnt_q == LAST);

  always_comb begin
    cnt_d      = cnt_q;
    program_d  = accept;
    scan_tag_d = accept ? cfg_tag : '0;
    if (restart) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q      <= '0;
      program_q  <= 1'b0;
      scan_tag_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      program_q  <= program_d;
      scan_tag_q <= scan_tag_d;
    end
  end

  assign program_o = program_q;
  assign scan_tag  = scan_tag_q;

endmodule

// File: rtl/multicast_dispatcher.sv
// Multicast dispatcher: programs the unit scan chain, then drives one tagged bus transfer at a time.
// Latency 1 cycle accept->enable; in_ready low while busy/programming. Watchdog under MCAST_TIMEOUT_EN.
module multicast_dispatcher
  import multicast_dispatcher_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int BITWIDTH       = DEF_BITWIDTH,
  parameter int NUM_UNITS      = DEF_NUM_UNITS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     cfg_valid,
  input  logic [ADDRESS_WIDTH-1:0] cfg_tag,
  output logic                     cfg_ready,
  input  logic                     reprog,
  input  logic                     in_valid,
  input  logic [ADDRESS_WIDTH-1:0] in_tag,
  input  logic [BITWIDTH-1:0]      in_data,
  output logic                     in_ready,
  output logic                     program_o,
  output logic [ADDRESS_WIDTH-1:0] scan_tag,
  output logic                     enable,
  output logic [ADDRESS_WIDTH-1:0] tag,
  output logic [BITWIDTH-1:0]      bus_data,
  input  logic                     bus_ready,
  output logic                     programmed,
  output logic                     err_timeout
);

  state_t                   state_q, state_d;
  logic                     enable_q, enable_d;
  logic [ADDRESS_WIDTH-1:0] tag_q, tag_d;
  logic [BITWIDTH-1:0]      bus_data_q, bus_data_d;
  logic                     programmed_q, programmed_d;
  logic                     pend_reprog_q, pend_reprog_d;
  logic                     prog_done;
  logic                     xfer_end;
  logic                     timed_out;

  mcast_scan_programmer #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_UNITS     (NUM_UNITS)
  ) u_scan (
    .clk       (clk),
    .rstb      (rstb),
    .active    (state_q == S_PROG),
    .restart   (reprog),
    .cfg_valid (cfg_valid),
    .cfg_tag   (cfg_tag),
    .cfg_ready (cfg_ready),
    .program_o (program_o),
    .scan_tag  (scan_tag),
    .done      (prog_done)
  );

`ifdef MCAST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_timeout_q, err_timeout_d;

  assign timed_out = (state_q == S_BUSY) && !bus_ready && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d    = '0;
    err_timeout_d = timed_out;
    if (state_q == S_BUSY && !xfer_end) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  assign xfer_end = (state_q == S_BUSY) && (bus_ready || timed_out);
  assign in_ready = (state_q == S_RUN) && !reprog;

  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    tag_d         = tag_q;
    bus_data_d    = bus_data_q;
    programmed_d  = programmed_q;
    pend_reprog_d = pend_reprog_q;
    case (state_q)
      S_PROG: begin
        pend_reprog_d = 1'b0;
        if (prog_done) begin
          state_d      = S_RUN;
          programmed_d = 1'b1;
        end
      end
      S_RUN: begin
        if (reprog) begin
          state_d      = S_PROG;
          programmed_d = 1'b0;
        end else if (in_valid) begin
          state_d    = S_BUSY;
          enable_d   = 1'b1;
          tag_d      = in_tag;
          bus_data_d = in_data;
        end
      end
      S_BUSY: begin
        if (reprog) pend_reprog_d = 1'b1;
        if (xfer_end) begin
          enable_d   = 1'b0;
          bus_data_d = '0;
          // A reprog seen at any point during the transfer redirects the return to programming.
          if (pend_reprog_q || reprog) begin
            state_d       = S_PROG;
            programmed_d  = 1'b0;
            pend_reprog_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_PROG;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= S_PROG;
      enable_q      <= 1'b0;
      tag_q         <= '0;
      bus_data_q    <= '0;
      programmed_q  <= 1'b0;
      pend_reprog_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      tag_q         <= tag_d;
      bus_data_q    <= bus_data_d;
      programmed_q  <= programmed_d;
      pend_reprog_q <= pend_reprog_d;
    end
  end

  assign enable     = enable_q;
  assign tag        = tag_q;
  assign bus_data   = bus_data_q;
  assign programmed = programmed_q;

endmodule

// File: tb/tb_multicast_dispatcher.sv
// Directed bench for multicast_dispatcher: programming, transfers, reprog, reset, watchdog.
module tb_multicast_dispatcher;
  localparam int AW = 4;
  localparam int BW = 16;
  localparam int NU = 8;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [AW-1:0] cfg_tag = '0;
  logic          cfg_ready;
  logic          reprog = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_tag = '0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready;
  logic          program_o;
  logic [AW-1:0] scan_tag;
  logic          enable;
  logic [AW-1:0] tag;
  logic [BW-1:0] bus_data;
  logic          bus_ready = 1'b0;
  logic          programmed;
  logic          err_timeout;

  int vectors = 0;
  int miscompares = 0;

  multicast_dispatcher #(
    .ADDRESS_WIDTH (AW),
    .BITWIDTH      (BW),
    .NUM_UNITS     (NU),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .cfg_valid  (cfg_valid),
    .cfg_tag    (cfg_tag),
    .cfg_ready  (cfg_ready),
    .reprog     (reprog),
    .in_valid   (in_valid),
    .in_tag     (in_tag),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .program_o  (program_o),
    .scan_tag   (scan_tag),
    .enable     (enable),
    .tag        (tag),
    .bus_data   (bus_data),
    .bus_ready  (bus_ready),
    .programmed (programmed),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_cfg(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_tag   = AW'(n - 1 - i);
      step();
    end
    cfg_valid = 1'b0;
    cfg_tag   = '0;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #12;
    vectors++;
    if ({program_o, scan_tag, enable, tag, bus_data, programmed, err_timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got prog=%b scan=%h en=%b tag=%h data=%h pgm=%b err=%b want all 0",
               program_o, scan_tag, enable, tag, bus_data, programmed, err_timeout);
    end
    vectors++;
    if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got cfg_ready=%b in_ready=%b want 1/0", cfg_ready, in_ready);
    end
    step();
    rstb = 1'b1;
    step();
  endtask

  task automatic test_program();
    for (int i = 0; i < NU; i++) begin
      cfg_valid = 1'b1;
      cfg_tag   = AW'(7 - i);
      step();
      vectors++;
      if (program_o !== 1'b1 || scan_tag !== AW'(7 - i)) begin
        miscompares++;
        $display("FAIL prog_pulse[%0d]: got prog=%b scan=%h want 1/%h", i, program_o, scan_tag, AW'(7 - i));
      end
      vectors++;
      if (programmed !== (i == NU - 1)) begin
        miscompares++;
        $display("FAIL programmed_edge[%0d]: got %b want %b", i, programmed, (i == NU - 1));
      end
    end
    cfg_valid = 1'b0;
    step();
    vectors++;
    if (program_o !== 1'b0 || programmed !== 1'b1 || cfg_ready !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL prog_done: got prog=%b pgm=%b cfg_ready=%b in_ready=%b want 0/1/0/1",
               program_o, programmed, cfg_ready, in_ready);
    end
  endtask

  task automatic test_transfer();
    in_valid = 1'b1; in_tag = 4'd3; in_data = 16'h1234; bus_ready = 1'b0;
    step();
    in_valid = 1'b0;
    vectors++;
    if (enable !== 1'b1 || tag !== 4'd3 || bus_data !== 16'h1234 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL xfer_start: got en=%b tag=%h data=%h in_ready=%b want 1/3/1234/0", enable, tag, bus_data, in_ready);
    end
    step();
    vectors++;
    if (enable !== 1'b1 || tag !== 4'd3 || bus_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL xfer_hold: got en=%b tag=%h data=%h want 1/3/1234", enable, tag, bus_data);
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    vectors++;
    if (enable !== 1'b0 || bus_data !== 16'h0000 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL xfer_end: got en=%b data=%h in_ready=%b want 0/0000/1", enable, bus_data, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_tag = 4'd5; in_data = 16'hAAAA; bus_ready = 1'b1;
    step();
    in_tag = 4'd6; in_data = 16'h5555;
    vectors++;
    if (enable !== 1'b1 || tag !== 4'd5 || bus_data !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL b2b_first: got en=%b tag=%h data=%h want 1/5/aaaa", enable, tag, bus_data);
    end
    step();
    vectors++;
    if (enable !== 1'b0 || bus_data !== 16'h0000 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap: got en=%b data=%h in_ready=%b want 0/0000/1", enable, bus_data, in_ready);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (enable !== 1'b1 || tag !== 4'd6 || bus_data !== 16'h5555) begin
      miscompares++;
      $display("FAIL b2b_second: got en=%b tag=%h data=%h want 1/6/5555", enable, tag, bus_data);
    end
    step();
    bus_ready = 1'b0;
    vectors++;
    if (enable !== 1'b0 || bus_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL b2b_done: got en=%b data=%h want 0/0000", enable, bus_data);
    end
  endtask

  task automatic test_cfg_ignored_in_run();
    cfg_valid = 1'b1; cfg_tag = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (program_o !== 1'b0 || cfg_ready !== 1'b0 || enable !== 1'b0 || programmed !== 1'b1) begin
        miscompares++;
        $display("FAIL cfg_in_run[%0d]: got prog=%b cfg_ready=%b en=%b pgm=%b want 0/0/0/1",
                 i, program_o, cfg_ready, enable, programmed);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reprog_busy();
    in_valid = 1'b1; in_tag = 4'd2; in_data = 16'hC0DE; bus_ready = 1'b0;
    step();
    in_valid = 1'b0;
    reprog   = 1'b1;
    step();
    reprog = 1'b0;
    vectors++;
    if (enable !== 1'b1 || bus_data !== 16'hC0DE || programmed !== 1'b1) begin
      miscompares++;
      $display("FAIL reprog_busy_hold: got en=%b data=%h pgm=%b want 1/c0de/1", enable, bus_data, programmed);
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    vectors++;
    if (enable !== 1'b0 || bus_data !== 16'h0000 || programmed !== 1'b0 || cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reprog_busy_end: got en=%b data=%h pgm=%b cfg_ready=%b in_ready=%b want 0/0000/0/1/0",
               enable, bus_data, programmed, cfg_ready, in_ready);
    end
    in_valid = 1'b1; in_tag = 4'd1; in_data = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (enable !== 1'b0 || bus_data !== 16'h0000 || in_ready !== 1'b0 || program_o !== 1'b0) begin
        miscompares++;
        $display("FAIL in_in_prog[%0d]: got en=%b data=%h in_ready=%b prog=%b want 0/0000/0/0",
                 i, enable, bus_data, in_ready, program_o);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reprog_restart();
    feed_cfg(3);
    reprog = 1'b1;
    step();
    reprog = 1'b0;
    feed_cfg(NU - 1);
    vectors++;
    if (programmed !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_count7: got pgm=%b want 0", programmed);
    end
    feed_cfg(1);
    vectors++;
    if (programmed !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_count8: got pgm=%b in_ready=%b want 1/1", programmed, in_ready);
    end
  endtask

  task automatic test_reprog_run();
    in_valid = 1'b1; in_tag = 4'd4; in_data = 16'h4444; reprog = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reprog_wins_ready: got in_ready=%b want 0", in_ready);
    end
    step();
    in_valid = 1'b0; reprog = 1'b0;
    vectors++;
    if (enable !== 1'b0 || programmed !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reprog_run: got en=%b pgm=%b cfg_ready=%b want 0/0/1", enable, programmed, cfg_ready);
    end
    feed_cfg(NU);
  endtask

  task automatic test_timeout();
    in_valid = 1'b1; in_tag = 4'd7; in_data = 16'h7777; bus_ready = 1'b0;
    step();
    in_valid = 1'b0;
`ifdef MCAST_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      vectors++;
      if (enable !== 1'b1 || err_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL to_wait[%0d]: got en=%b err=%b want 1/0", i, enable, err_timeout);
      end
    end
    step();
    vectors++;
    if (enable !== 1'b0 || bus_data !== 16'h0000 || err_timeout !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL to_abort: got en=%b data=%h err=%b in_ready=%b want 0/0000/1/1",
               enable, bus_data, err_timeout, in_ready);
    end
    step();
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL to_pulse: got err=%b want 0", err_timeout);
    end
`else
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      vectors++;
      if (enable !== 1'b1 || err_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL no_to_wait[%0d]: got en=%b err=%b want 1/0", i, enable, err_timeout);
      end
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    vectors++;
    if (enable !== 1'b0 || err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL no_to_end: got en=%b err=%b want 0/0", enable, err_timeout);
    end
`endif
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_tag = 4'd9; in_data = 16'hBEEF; bus_ready = 1'b0;
    step();
    in_valid = 1'b0;
    vectors++;
    if (enable !== 1'b1 || bus_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got en=%b data=%h want 1/beef", enable, bus_data);
    end
    #2 rstb = 1'b0;
    #1;
    vectors++;
    if ({program_o, scan_tag, enable, tag, bus_data, programmed, err_timeout} !== '0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid: got en=%b tag=%h data=%h pgm=%b cfg_ready=%b want 0/0/0000/0/1",
               enable, tag, bus_data, programmed, cfg_ready);
    end
    step();
    step();
    rstb = 1'b1;
    step();
    vectors++;
    if (enable !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_after: got en=%b in_ready=%b cfg_ready=%b want 0/0/1", enable, in_ready, cfg_ready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_transfer();
    test_back_to_back();
    test_cfg_ignored_in_run();
    test_reprog_busy();
    test_reprog_restart();
    test_reprog_run();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicast_dispatcher.md
MULTICAST_DISPATCHER -- requirements
Module: multicast_dispatcher

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 4: tag and scan-chain ID width.
REQ-002 Parameter BITWIDTH, default 16: data word width.
REQ-003 Parameter NUM_UNITS, default 8: scan-chain length; number of program cycles per configuration.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: watchdog limit, used only under REQ-027.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rstb  in  1  reset, asynchronous, active-low.
REQ-007 cfg_valid  in  1, cfg_tag  in  ADDRESS_WIDTH, cfg_ready  out  1: scan-ID stream.
REQ-008 reprog  in  1  single-cycle request to re-enter programming.
REQ-009 in_valid  in  1, in_tag  in  ADDRESS_WIDTH, in_data  in  BITWIDTH, in_ready  out  1: multicast request stream.
REQ-010 program  out  1, scan_tag  out  ADDRESS_WIDTH: scan-chain drive to first unit controller.
REQ-011 enable  out  1, tag  out  ADDRESS_WIDTH, bus_data  out  BITWIDTH: multicast bus drive.
REQ-012 bus_ready  in  1  aggregated unit_ready of addressed units.
REQ-013 programmed  out  1, err_timeout  out  1.

Function
REQ-014 States SHALL be S_PROG, S_RUN, S_BUSY, encoded in 2 bits.
REQ-015 S_PROG: cfg_ready=1; each cfg_valid&cfg_ready cycle SHALL register program=1, scan_tag=cfg_tag for exactly the next cycle, then program=0.
REQ-016 Program-cycle counter SHALL count accepted cfg tags 0..NUM_UNITS-1; on the NUM_UNITS-th acceptance, transition to S_RUN, counter clears, programmed=1 from the next cycle.
REQ-017 First accepted cfg tag SHALL end in the unit farthest down the chain; last accepted in the nearest unit.
REQ-018 cfg_valid outside S_PROG SHALL be ignored (cfg_ready=0); in_valid in S_PROG SHALL be ignored (in_ready=0).
REQ-019 S_RUN: in_ready=1; on in_valid, tag<=in_tag, bus_data<=in_data, enable<=1 on the next edge; go to S_BUSY.
REQ-020 S_BUSY: in_ready=0; enable, tag, bus_data SHALL hold stable until a cycle with bus_ready=1; that edge clears enable, zeroes bus_data, returns to S_RUN.
REQ-021 Throughput: at most one transfer per two cycles; latency in_valid accept to enable=1 is one cycle.
REQ-022 bus_data SHALL be zero whenever enable=0.
REQ-023 reprog in S_RUN: next state S_PROG, programmed=0, counter cleared. reprog in S_BUSY: latched, applied when the transfer completes (instead of S_RUN). reprog in S_PROG: restarts count at 0.
REQ-024 reprog and in_valid in the same S_RUN cycle: reprog wins, in_ready=0 that cycle.

Reset
REQ-025 On rstb low, asynchronously: state S_PROG, counter 0, program=0, scan_tag=0, enable=0, tag=0, bus_data=0, programmed=0, err_timeout=0, pending reprog cleared.
REQ-026 Reset mid-transfer SHALL drop the transfer with no completion indication.

Configuration
REQ-027 Macro MCAST_TIMEOUT_EN defined: S_BUSY wait counter; when TIMEOUT_CYCLES cycles elapse without bus_ready, transfer aborts as in REQ-020 and err_timeout pulses high one cycle. Undefined: no counter, S_BUSY waits indefinitely, err_timeout tied 0.

Structure
REQ-028 Shared package SHALL hold the state encoding constants and default ADDRESS_WIDTH/BITWIDTH.
REQ-029 One sub-module, mcast_scan_programmer (REQ-015..017 counter and program/scan_tag registers), is natural; remainder flat.

Verification
REQ-030 Reset, stream 8 cfg tags 7..0 back-to-back -> 8 single-cycle program pulses with scan_tag 7..0, programmed=1 one cycle after last.
REQ-031 In S_RUN, in_tag=3, in_data=0x1234, bus_ready=1 two cycles later -> enable=1, tag=3, bus_data=0x1234 held until that edge, then enable=0, bus_data=0.
REQ-032 reprog asserted during S_BUSY -> transfer completes normally, then state S_PROG, programmed=0, cfg_ready=1.
REQ-033 rstb low while enable=1 -> all outputs zero immediately, state S_PROG.
REQ-034 MCAST_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready held 0 -> enable drops after 4 cycles, one-cycle err_timeout, in_ready=1 next cycle.
REQ-035 in_valid during S_PROG and cfg_valid during S_RUN -> no bus or program activity.
